jtcps1_pal_dma: RTL and testbench



---
 rtl/jtcps1_pal_dma.sv | 171 +++++++++++++++++
 tb/tb_jtcps1_pal_dma.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcps1_pal_dma.sv
// jtcps1_pal_dma: copies the enabled palette pages from VRAM into the
// internal palette RAM after a single pal_copy pulse.
//
// Optional feature macro: JTCPS1_PALDMA_QUEUE_EN
//   defined     : a pal_copy seen while busy is remembered (one deep) and a
//                 fresh copy starts straight from DONE without dropping busy.
//   not defined : a pal_copy seen while busy is ignored.
//
// VRAM handshake: vram_req rises with vram_addr already valid and both hold
// steady until the cycle vram_ok=1, in which vram_data is captured; vram_ok
// in any other state is ignored.
// All outputs are registered. state_dbg mirrors the FSM state.
module jtcps1_pal_dma #(
   parameter  int PAGES      = 6,
   parameter  int PAGE_WORDS = 512,
   localparam int PW         = (PAGES > 1) ? $clog2(PAGES) : 1,
   localparam int WW         = $clog2(PAGE_WORDS)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              pal_copy,
   input  logic [15:0]       pal_base,
   input  logic [PAGES-1:0]  pal_page_en,
   output logic              vram_req,
   output logic [22:0]       vram_addr,
   input  logic              vram_ok,
   input  logic [15:0]       vram_data,
   output logic              pal_we,
   output logic [PW+WW-1:0]  pal_addr,
   output logic [15:0]       pal_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      READ  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state;
   logic [22:0]       a0;     // VRAM start word address latched at start
   logic [22:0]       src;    // words read so far (compact over enabled pages)
   logic [PAGES-1:0]  mask;
   logic [PW-1:0]     page;
   logic [WW-1:0]     word;
   logic              last_page;
   logic              last_word;

   assign last_page = (page == PW'(PAGES-1));
   assign last_word = (word == WW'(PAGE_WORDS-1));
   assign state_dbg = state;

`ifdef JTCPS1_PALDMA_QUEUE_EN
   logic pending;

   // Remembers one start request arriving while a copy is running.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pending <= 1'b0;
      end else if (state == DONE) begin
         pending <= 1'b0;   // consumed (or merged) by the restart below
      end else if (busy && pal_copy) begin
         pending <= 1'b1;
      end
   end
`endif

   // Copy sequencer with registered handshake and palette write outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         a0        <= '0;
         src       <= '0;
         mask      <= '0;
         page      <= '0;
         word      <= '0;
         vram_req  <= 1'b0;
         vram_addr <= '0;
         pal_we    <= 1'b0;
         pal_addr  <= '0;
         pal_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pal_copy) begin
                  a0    <= {pal_base, 7'd0};
                  mask  <= pal_page_en;
                  page  <= '0;
                  src   <= '0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (mask[page]) begin
                  word      <= '0;
                  vram_req  <= 1'b1;
                  vram_addr <= a0 + src;
                  state     <= READ;
               end else if (last_page) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  page <= page + PW'(1);
               end
            end
            READ: begin
               if (vram_ok) begin
                  vram_req <= 1'b0;
                  pal_we   <= 1'b1;
                  pal_addr <= {page, word};
                  pal_data <= vram_data;
                  state    <= WRITE;
               end
            end
            WRITE: begin
               pal_we <= 1'b0;
               src    <= src + 23'd1;
               word   <= word + WW'(1);
               if (last_word) begin
                  // The final page goes straight to DONE so the last page
                  // does not cost an extra SCAN cycle.
                  if (last_page) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     page  <= page + PW'(1);
                     state <= SCAN;
                  end
               end else begin
                  vram_req  <= 1'b1;
                  vram_addr <= a0 + src + 23'd1;
                  state     <= READ;
               end
            end
            DONE: begin
               done <= 1'b0;
`ifdef JTCPS1_PALDMA_QUEUE_EN
               if (pending || pal_copy) begin
                  a0    <= {pal_base, 7'd0};
                  mask  <= pal_page_en;
                  page  <= '0;
                  src   <= '0;
                  state <= SCAN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
`else
               busy  <= 1'b0;
               state <= IDLE;
`endif
            end
            default: begin
               vram_req <= 1'b0;
               pal_we   <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Bench for jtcps1_pal_dma: a VRAM model whose data is a function of the
// address, a scoreboard of expected VRAM addresses and palette writes
// pushed when each copy is started, and a linear list of directed tests.
module tb_jtcps1_pal_dma;

   logic        clk;
   logic        rstn;
   logic        pal_copy;
   logic [15:0] pal_base;
   logic [5:0]  pal_page_en;
   logic        vram_req;
   logic [22:0] vram_addr;
   logic        vram_ok;
   logic [15:0] vram_data;
   logic        pal_we;
   logic [11:0] pal_addr;
   logic [15:0] pal_data;
   logic        busy;
   logic        done;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   // scoreboard queues
   logic [22:0] exp_va_q[$];
   logic [27:0] exp_q[$];

   // monitor counters
   int          we_cnt, ok_cnt, busy_cycles, done_cnt, req_cycles;
   logic [22:0] first_va, last_va;
   logic        prev_req, prev_acc;
   logic [22:0] prev_addr;

   bit stall_mode = 1'b0;
   int wait_left  = 0;

   jtcps1_pal_dma dut (
      .clk         (clk),
      .rstn        (rstn),
      .pal_copy    (pal_copy),
      .pal_base    (pal_base),
      .pal_page_en (pal_page_en),
      .vram_req    (vram_req),
      .vram_addr   (vram_addr),
      .vram_ok     (vram_ok),
      .vram_data   (vram_data),
      .pal_we      (pal_we),
      .pal_addr    (pal_addr),
      .pal_data    (pal_data),
      .busy        (busy),
      .done        (done),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] vmem(input logic [22:0] a);
      return a[15:0] ^ {a[22:16], a[22:14]};
   endfunction

   assign vram_data = vmem(vram_addr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // VRAM acknowledge driver: tied high, or random 0..5 cycle stalls per request
   initial begin
      vram_ok = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!stall_mode) begin
            vram_ok = 1'b1;
         end else if (vram_req && wait_left == 0) begin
            vram_ok   = 1'b1;
            wait_left = $urandom_range(0, 5);
         end else begin
            vram_ok = 1'b0;
            if (vram_req && wait_left > 0) wait_left--;
         end
      end
   end

   // monitor: pops the scoreboard on every accepted read and palette write
   always @(negedge clk) begin
      if (rstn) begin
         if (vram_req) req_cycles++;
         if (prev_req && !prev_acc && vram_req)
            chk("addr_stable", 64'(vram_addr), 64'(prev_addr));
         if (vram_req && vram_ok) begin
            if (ok_cnt == 0) first_va = vram_addr;
            last_va = vram_addr;
            ok_cnt++;
            if (exp_va_q.size() == 0) chk("va_unexpected", 64'(vram_addr), 64'h7fffffffffffffff);
            else chk("vram_addr", 64'(vram_addr), 64'(exp_va_q.pop_front()));
         end
         if (pal_we) begin
            we_cnt++;
            chk("req_low_in_write", 64'(vram_req), 64'd0);
            if (exp_q.size() == 0) chk("we_unexpected", 64'({pal_addr, pal_data}), 64'h7fffffffffffffff);
            else chk("pal_write", 64'({pal_addr, pal_data}), 64'(exp_q.pop_front()));
         end
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         prev_req  = vram_req;
         prev_acc  = vram_req && vram_ok;
         prev_addr = vram_addr;
      end else begin
         prev_req = 1'b0;
         prev_acc = 1'b0;
      end
   end

   task automatic clear_counts();
      we_cnt = 0; ok_cnt = 0; busy_cycles = 0; done_cnt = 0; req_cycles = 0;
      first_va = '0; last_va = '0;
   endtask

   task automatic push_exp(input logic [15:0] base, input logic [5:0] mask);
      logic [22:0] a0;
      logic [22:0] src;
      logic [22:0] va;
      a0  = {base, 7'd0};
      src = '0;
      for (int p = 0; p < 6; p++) begin
         if (mask[p]) begin
            for (int w = 0; w < 512; w++) begin
               va = a0 + src;
               exp_va_q.push_back(va);
               exp_q.push_back({3'(p), 9'(w), vmem(va)});
               src = src + 23'd1;
            end
         end
      end
   endtask

   // called at a negedge; returns at the negedge after the pulse
   task automatic start_copy(input logic [15:0] base, input logic [5:0] mask);
      chk("idle_before_start", 64'(busy), 64'd0);
      clear_counts();
      pal_base    = base;
      pal_page_en = mask;
      pal_copy    = 1'b1;
      push_exp(base, mask);
      @(negedge clk);
      pal_copy = 1'b0;
      chk("busy_rise", 64'(busy), 64'd1);
   endtask

   task automatic wait_idle(input int max, input string tag);
      for (int i = 0; i < max; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk(tag, 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_va_q_empty"}, 64'(exp_va_q.size()), 64'd0);
      chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_we_per_ok"}, 64'(we_cnt), 64'(ok_cnt));
   endtask

   // directed sequence
   initial begin
      logic [5:0]  rmask;
      logic [15:0] rbase;
      rstn = 1'b0; pal_copy = 1'b0; pal_base = '0; pal_page_en = '0;
      clear_counts();
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({vram_req, vram_addr, pal_we, pal_addr, pal_data, busy, done, state_dbg}), 64'd0);
      rstn = 1'b1;
      @(negedge clk);

      // 1: all pages, ok tied high
      start_copy(16'h0040, 6'h3f);
      wait_idle(20000, "t1_timeout");
      chk("t1_writes", 64'(we_cnt), 64'd3072);
      chk("t1_first_va", 64'(first_va), 64'h2000);
      chk("t1_last_va", 64'(last_va), 64'h2bff);
      chk("t1_busy_len", 64'(busy_cycles), 64'd6151);
      chk("t1_done", 64'(done_cnt), 64'd1);
      check_drained("t1");

      // 2: pages 0 and 2, compact source
      start_copy(16'h0010, 6'b000101);
      wait_idle(20000, "t2_timeout");
      chk("t2_writes", 64'(we_cnt), 64'd1024);
      chk("t2_busy_len", 64'(busy_cycles), 64'd2055);
      chk("t2_done", 64'(done_cnt), 64'd1);
      check_drained("t2");

      // 3: no pages enabled
      start_copy(16'h1234, 6'h00);
      wait_idle(100, "t3_timeout");
      chk("t3_writes", 64'(we_cnt), 64'd0);
      chk("t3_no_req", 64'(req_cycles), 64'd0);
      chk("t3_busy_len", 64'(busy_cycles), 64'd7);
      chk("t3_done", 64'(done_cnt), 64'd1);

      // 4: random stalls, random base and mask
      stall_mode = 1'b1;
      rmask = 6'($urandom_range(1, 63));
      rbase = 16'($urandom_range(0, 65535));
      start_copy(rbase, rmask);
      wait_idle(40000, "t4_timeout");
      chk("t4_writes", 64'(we_cnt), 64'($countones(rmask) * 512));
      chk("t4_done", 64'(done_cnt), 64'd1);
      check_drained("t4");
      stall_mode = 1'b0;
      repeat (2) @(negedge clk);

      // 5: address wrap
      start_copy(16'hffff, 6'b000001);
      wait_idle(5000, "t5_timeout");
      chk("t5_first_va", 64'(first_va), 64'h7fff80);
      chk("t5_last_va", 64'(last_va), 64'h00017f);
      chk("t5_busy_len", 64'(busy_cycles), 64'd1031);
      check_drained("t5");

      // 6: second pal_copy mid-copy, with new base/mask on the inputs
      start_copy(16'h0100, 6'b000001);
      repeat (100) @(negedge clk);
      pal_base    = 16'h0200;
      pal_page_en = 6'b000010;
      pal_copy    = 1'b1;
`ifdef JTCPS1_PALDMA_QUEUE_EN
      push_exp(16'h0200, 6'b000010);
`endif
      @(negedge clk);
      pal_copy = 1'b0;
      wait_idle(10000, "t6_timeout");
`ifdef JTCPS1_PALDMA_QUEUE_EN
      chk("t6_writes", 64'(we_cnt), 64'd1024);
      chk("t6_done", 64'(done_cnt), 64'd2);
      chk("t6_busy_len", 64'(busy_cycles), 64'd2062);
`else
      chk("t6_writes", 64'(we_cnt), 64'd512);
      chk("t6_done", 64'(done_cnt), 64'd1);
      chk("t6_busy_len", 64'(busy_cycles), 64'd1031);
`endif
      check_drained("t6");

      // 7: reset mid-page
      start_copy(16'h0040, 6'h3f);
      repeat (300) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("t7_reset_outputs", 64'({vram_req, vram_addr, pal_we, pal_addr, pal_data, busy, done, state_dbg}), 64'd0);
      exp_va_q.delete();
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      clear_counts();
      repeat (20) @(negedge clk);
      chk("t7_no_writes", 64'(we_cnt), 64'd0);
      chk("t7_no_req", 64'(req_cycles), 64'd0);
      chk("t7_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
